// File: rtl/narrow_pkg.sv
// Shared types and constants for the int8 -> int4 narrowing stream.
// The optional round-to-nearest conversion is selected by the NARROW_ROUND_EN macro.
package narrow_pkg;

  typedef logic [1:0]        uint2_t;
  typedef logic signed [3:0] int4_t;
  typedef logic signed [7:0] int8_t;
  typedef int8_t             char_t;

  localparam int4_t INT4_MAX = 4'sd7;
  localparam int4_t INT4_MIN = -4'sd8;

  typedef enum uint2_t {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    int4_t data;
    logic  sat;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{data: 4'sd0, sat: 1'b0};

endpackage

// File: rtl/int8_to_int4_sat.sv
// Combinational int8 -> int4 conversion with saturation indication.
// NARROW_ROUND_EN selects scale-by-1/16 with round-half-up; otherwise a plain clamp.
module int8_to_int4_sat
  import narrow_pkg::*;
(
  input  int8_t din_i,
  output int4_t dout_o,
  output logic  sat_o
);

`ifdef NARROW_ROUND_EN
  logic signed [8:0] sum_s;
  logic signed [8:0] t_s;

  // Bias by half an output step, then arithmetic shift; only the top end can overflow.
  always_comb begin
    sum_s  = {din_i[7], din_i} + 9'sd8;
    t_s    = sum_s >>> 4;
    dout_o = t_s[3:0];
    sat_o  = 1'b0;
    if (t_s > 9'sd7) begin
      dout_o = INT4_MAX;
      sat_o  = 1'b1;
    end else begin
      dout_o = t_s[3:0];
      sat_o  = 1'b0;
    end
  end
`else
  // Signed clamp into the int4 range; in-range values keep their low nibble.
  always_comb begin
    dout_o = din_i[3:0];
    sat_o  = 1'b0;
    if (din_i > 8'sd7) begin
      dout_o = INT4_MAX;
      sat_o  = 1'b1;
    end else if (din_i < -8'sd8) begin
      dout_o = INT4_MIN;
      sat_o  = 1'b1;
    end else begin
      dout_o = din_i[3:0];
      sat_o  = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/int8_narrow_stream.sv
// Streaming int8 -> int4 narrower with a 2-entry output buffer and saturation statistics.
// Conversion flavour is chosen in int8_to_int4_sat via the NARROW_ROUND_EN macro.
module int8_narrow_stream
  import narrow_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_sat,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  occ_e             state_q, state_d;
  entry_t           buf0_q, buf0_d;
  entry_t           buf1_q, buf1_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  int4_t  conv_data_s;
  logic   conv_sat_s;
  entry_t conv_s;
  logic   push_s;
  logic   pop_s;

  int8_to_int4_sat u_conv (
    .din_i  (int8_t'(in_data)),
    .dout_o (conv_data_s),
    .sat_o  (conv_sat_s)
  );

  assign conv_s = '{data: conv_data_s, sat: conv_sat_s};
  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;

  // Occupancy FSM and buffer shifting; entry 0 is always the head.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      EMPTY: begin
        if (push_s) begin
          buf0_d  = conv_s;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          buf0_d  = conv_s;
        end else if (push_s) begin
          buf1_d  = conv_s;
          state_d = TWO;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          buf0_d  = buf1_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Saturation statistics: a saturating push overrides a same-cycle clear.
  always_comb begin
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (push_s && conv_sat_s) begin
      sat_flag_d = 1'b1;
      if (clr) begin
        sat_count_d = CNT_ONE;
      end else if (&sat_count_q) begin
        sat_count_d = sat_count_q;
      end else begin
        sat_count_d = sat_count_q + CNT_ONE;
      end
    end else if (clr) begin
      sat_flag_d  = 1'b0;
      sat_count_d = '0;
    end else begin
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
    end
  end

  // State, buffer and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      buf0_q      <= ENTRY_ZERO;
      buf1_q      <= ENTRY_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = buf0_q.data;
  assign out_sat   = buf0_q.sat;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_int8_narrow_stream.sv
// Directed self-checking bench for int8_narrow_stream (default and NARROW_ROUND_EN builds).
module tb_int8_narrow_stream;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, out_sat, sat_flag, clr;
  logic signed [7:0] in_data;
  logic signed [3:0] out_data;
  logic [7:0]        sat_count;

  logic              in_valid2, in_ready2, out_valid2, out_sat2, sat_flag2, clr2;
  logic signed [7:0] in_data2;
  logic signed [3:0] out_data2;
  logic [1:0]        sat_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int8_narrow_stream #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_flag(sat_flag), .sat_count(sat_count), .clr(clr)
  );

  int8_narrow_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_sat(out_sat2),
    .sat_flag(sat_flag2), .sat_count(sat_count2), .clr(clr2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string tag, input logic signed [7:0] d, input int ed, input int es);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'(out_data), ed);
    check({tag, "_sat"}, int'(out_sat), es);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'sd0; out_ready = 1'b0; clr = 1'b0;
    in_valid2 = 1'b0; in_data2 = 8'sd0; clr2 = 1'b0;
    tick(); tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_sat_count", int'(sat_count), 0);
    rst_n = 1'b1;
    tick();

    // clamp vectors, streaming with out_ready high
    out_ready = 1'b1;
`ifdef NARROW_ROUND_EN
    push_chk("clamp0", 8'sd5, 0, 0);
    push_chk("clamp1", 8'sd100, 6, 0);
    push_chk("clamp2", -8'sd128, -8, 0);
    push_chk("clamp3", -8'sd8, 0, 0);
`else
    push_chk("clamp0", 8'sd5, 5, 0);
    push_chk("clamp1", 8'sd100, 7, 1);
    push_chk("clamp2", -8'sd128, -8, 1);
    push_chk("clamp3", -8'sd8, -8, 0);
`endif
    in_valid = 1'b0;
    tick();
    check("clamp_drain_valid", int'(out_valid), 0);
`ifdef NARROW_ROUND_EN
    check("clamp_sat_count", int'(sat_count), 0);
    check("clamp_sat_flag", int'(sat_flag), 0);
`else
    check("clamp_sat_count", int'(sat_count), 2);
    check("clamp_sat_flag", int'(sat_flag), 1);
`endif

    // throughput: one sample per cycle, in_ready never drops
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i - 4);
      tick();
      check("thru_in_ready", int'(in_ready), 1);
      check("thru_valid", int'(out_valid), 1);
`ifdef NARROW_ROUND_EN
      check("thru_data", int'(out_data), 0);
`else
      check("thru_data", int'(out_data), i - 4);
`endif
    end
    in_valid = 1'b0;
    tick();

    // backpressure: two accepted, third refused, head stable
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'sd40;
    tick();
    check("bp_ready1", int'(in_ready), 1);
    in_data = -8'sd40;
    tick();
    check("bp_ready2", int'(in_ready), 0);
    in_data = 8'sd100;
    tick();
    check("bp_ready3", int'(in_ready), 0);
`ifdef NARROW_ROUND_EN
    check("bp_head_stable", int'(out_data), 3);
`else
    check("bp_head_stable", int'(out_data), 7);
`endif
    tick();
`ifdef NARROW_ROUND_EN
    check("bp_head_stable2", int'(out_data), 3);
`else
    check("bp_head_stable2", int'(out_data), 7);
    check("bp_head_sat", int'(out_sat), 1);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_pop1_ready", int'(in_ready), 1);
    check("bp_pop1_valid", int'(out_valid), 1);
`ifdef NARROW_ROUND_EN
    check("bp_second", int'(out_data), -2);
`else
    check("bp_second", int'(out_data), -8);
`endif
    tick();
    check("bp_drained", int'(out_valid), 0);

    // async reset with two entries buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'sd120;
    tick(); tick();
    in_valid = 1'b0;
    check("ar_full", int'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_in_ready", int'(in_ready), 1);
    check("ar_sat_count", int'(sat_count), 0);
    check("ar_sat_flag", int'(sat_flag), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_no_output", int'(out_valid), 0);

    // counter saturation on CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; in_data2 = 8'sd127;
      tick();
    end
    check("cnt_hold", int'(sat_count2), 3);
    check("cnt_flag", int'(sat_flag2), 1);
    clr2 = 1'b1;
    tick();
    check("cnt_clr_push", int'(sat_count2), 1);
    check("cnt_clr_push_flag", int'(sat_flag2), 1);
    in_valid2 = 1'b0;
    tick();
    check("cnt_clr_only", int'(sat_count2), 0);
    check("cnt_clr_only_flag", int'(sat_flag2), 0);
    clr2 = 1'b0;
    tick();

    // rounding-mode vectors
`ifdef NARROW_ROUND_EN
    push_chk("rnd0", 8'sd24, 2, 0);
    push_chk("rnd1", 8'sd23, 1, 0);
    push_chk("rnd2", -8'sd24, -1, 0);
    push_chk("rnd3", 8'sd127, 7, 1);
`else
    push_chk("rnd0", 8'sd24, 7, 1);
    push_chk("rnd1", 8'sd23, 7, 1);
    push_chk("rnd2", -8'sd24, -8, 1);
    push_chk("rnd3", 8'sd127, 7, 1);
`endif
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
